// File: rtl/writeback_stage.sv
// Writeback stage of the RV32I pipeline: accepts retiring instructions, waits
// for load responses, extends load data and drives the register-file write port.
module writeback_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValidM,
  output logic                     oReadyM,
  input  logic                     iRegWriteM,
  input  logic [ADDRESS_WIDTH-1:0] iRdM,
  input  logic [1:0]               iResultSrcM,
  input  logic [DATA_WIDTH-1:0]    iAluResultM,
  input  logic [DATA_WIDTH-1:0]    iPCPlus4M,
  input  logic [2:0]               iFunct3M,
  input  logic                     iMemRespValid,
  input  logic [DATA_WIDTH-1:0]    iMemRespData,
  output logic                     oWriteEn,
  output logic [ADDRESS_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0]    oDataIn,
  output logic                     oPendingValid,
  output logic [ADDRESS_WIDTH-1:0] oPendingRd,
  output logic [31:0]              oRetireCount
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_t;

  state_t r_state, w_state_next;

  // Holding register, captured on every transfer
  logic                     r_regwrite;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [1:0]               r_src;
  logic [2:0]               r_funct3;
  logic [1:0]               r_off;
  logic [DATA_WIDTH-1:0]    r_alu;
  logic [DATA_WIDTH-1:0]    r_pc4;

  logic                     r_write_en;
  logic [ADDRESS_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [31:0]              r_retire_count;

  logic                     w_ready;
  logic                     w_transfer;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_ext;
  logic                     w_we_next;
  logic [ADDRESS_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0]    w_data_next;

  function automatic logic [DATA_WIDTH-1:0] select_result(
    input logic [1:0]            src,
    input logic [DATA_WIDTH-1:0] alu,
    input logic [DATA_WIDTH-1:0] load,
    input logic [DATA_WIDTH-1:0] pc4
  );
    case (src)
      2'b01:   return load;
      2'b10:   return pc4;
      default: return alu;
    endcase
  endfunction

  // Ready is a pure function of state so there is no path from iValidM
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_transfer   = 1'b0;
    case (r_state)
      IDLE, WRITE: begin
        w_ready    = 1'b1;
        w_transfer = iValidM;
        if (iValidM) begin
          w_state_next = (iResultSrcM == 2'b01) ? WAIT_LOAD : WRITE;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (iMemRespValid) begin
          w_state_next = WRITE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = iMemRespData[7:0];
      2'd1:    w_byte = iMemRespData[15:8];
      2'd2:    w_byte = iMemRespData[23:16];
      default: w_byte = iMemRespData[31:24];
    endcase
    w_half = r_off[1] ? iMemRespData[31:16] : iMemRespData[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_ext = iMemRespData;
    endcase
  end

  // Non-loads enter WRITE straight from the inputs; loads from the holding register
  always_comb begin
    if (w_transfer) begin
      w_we_next   = iRegWriteM && (iRdM != '0);
      w_addr_next = iRdM;
      w_data_next = select_result(iResultSrcM, iAluResultM, '0, iPCPlus4M);
    end else begin
      w_we_next   = r_regwrite && (r_rd != '0);
      w_addr_next = r_rd;
      w_data_next = select_result(r_src, r_alu, w_ext, r_pc4);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state        <= IDLE;
      r_regwrite     <= 1'b0;
      r_rd           <= '0;
      r_src          <= '0;
      r_funct3       <= '0;
      r_off          <= '0;
      r_alu          <= '0;
      r_pc4          <= '0;
      r_write_en     <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
      r_retire_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_write_en <= 1'b0;
      if (w_transfer) begin
        r_regwrite <= iRegWriteM;
        r_rd       <= iRdM;
        r_src      <= iResultSrcM;
        r_funct3   <= iFunct3M;
        r_off      <= iAluResultM[1:0];
        r_alu      <= iAluResultM;
        r_pc4      <= iPCPlus4M;
      end
      if (w_state_next == WRITE) begin
        r_write_en     <= w_we_next;
        r_write_addr   <= w_addr_next;
        r_write_data   <= w_data_next;
        r_retire_count <= r_retire_count + 32'd1;
      end
    end
  end

  assign oReadyM       = w_ready;
  assign oWriteEn      = r_write_en;
  assign oWriteAddress = r_write_addr;
  assign oDataIn       = r_write_data;
  assign oRetireCount  = r_retire_count;
  assign oPendingValid = (r_state == WAIT_LOAD);
  assign oPendingRd    = ((r_state == WAIT_LOAD) && r_regwrite) ? r_rd : '0;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a behavioural
// model of the result-select and load-extension rules.
module tb_writeback_stage;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValidM;
  logic        oReadyM;
  logic        iRegWriteM;
  logic [4:0]  iRdM;
  logic [1:0]  iResultSrcM;
  logic [31:0] iAluResultM;
  logic [31:0] iPCPlus4M;
  logic [2:0]  iFunct3M;
  logic        iMemRespValid;
  logic [31:0] iMemRespData;
  logic        oWriteEn;
  logic [4:0]  oWriteAddress;
  logic [31:0] oDataIn;
  logic        oPendingValid;
  logic [4:0]  oPendingRd;
  logic [31:0] oRetireCount;

  int errors = 0;
  int checks = 0;
  int unsigned exp_count = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  always #5 iClk = ~iClk;

  writeback_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .iClk(iClk), .iRst(iRst), .iValidM(iValidM), .oReadyM(oReadyM),
    .iRegWriteM(iRegWriteM), .iRdM(iRdM), .iResultSrcM(iResultSrcM),
    .iAluResultM(iAluResultM), .iPCPlus4M(iPCPlus4M), .iFunct3M(iFunct3M),
    .iMemRespValid(iMemRespValid), .iMemRespData(iMemRespData),
    .oWriteEn(oWriteEn), .oWriteAddress(oWriteAddress), .oDataIn(oDataIn),
    .oPendingValid(oPendingValid), .oPendingRd(oPendingRd),
    .oRetireCount(oRetireCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the register file should receive, from the ISA rules
  function automatic logic [31:0] model_data(input logic [1:0] src, input logic [31:0] alu,
                                             input logic [31:0] pc4, input logic [2:0] f3,
                                             input logic [31:0] word);
    int unsigned off, b, h;
    if (src == 2'b10) return pc4;
    if (src != 2'b01) return alu;
    off = alu & 32'd3;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  // Starts and ends at a negedge with the stage idle
  task automatic run_op(input string tag, input logic [4:0] rd, input logic rw,
                        input logic [1:0] src, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [2:0] f3, input int lat, input logic [31:0] word);
    logic [31:0] exp_data;
    exp_data = model_data(src, alu, pc4, f3, word);
    check({tag, "/ready_idle"}, 32'(oReadyM), 32'd1);
    iValidM = 1'b1; iRegWriteM = rw; iRdM = rd; iResultSrcM = src;
    iAluResultM = alu; iPCPlus4M = pc4; iFunct3M = f3;
    @(negedge iClk);
    iValidM = 1'b0; iAluResultM = $urandom; iPCPlus4M = $urandom; iRdM = 5'($urandom);
    if (src == 2'b01) begin
      for (int k = 1; k <= lat; k++) begin
        check({tag, "/pending_valid"}, 32'(oPendingValid), 32'd1);
        check({tag, "/pending_rd"}, 32'(oPendingRd), rw ? 32'(rd) : 32'd0);
        check({tag, "/ready_wait"}, 32'(oReadyM), 32'd0);
        check({tag, "/we_wait"}, 32'(oWriteEn), 32'd0);
        if (k == lat) begin
          iMemRespValid = 1'b1; iMemRespData = word;
        end
        @(negedge iClk);
      end
      iMemRespValid = 1'b0; iMemRespData = $urandom;
    end
    exp_count++;
    last_addr = rd;
    last_data = exp_data;
    check({tag, "/we"}, 32'(oWriteEn), 32'(rw && (rd != 0)));
    check({tag, "/addr"}, 32'(oWriteAddress), 32'(rd));
    check({tag, "/data"}, oDataIn, exp_data);
    check({tag, "/pending_drop"}, 32'(oPendingValid), 32'd0);
    @(negedge iClk);
    check({tag, "/count"}, oRetireCount, exp_count);
    check({tag, "/we_after"}, 32'(oWriteEn), 32'd0);
    check({tag, "/data_hold"}, oDataIn, last_data);
  endtask

  initial begin
    logic [1:0]  r_src;
    logic [2:0]  r_f3;
    iRst = 1'b1; iValidM = 1'b0; iRegWriteM = 1'b0; iRdM = '0; iResultSrcM = '0;
    iAluResultM = '0; iPCPlus4M = '0; iFunct3M = '0; iMemRespValid = 1'b0; iMemRespData = '0;
    repeat (3) @(negedge iClk);
    check("rst/we", 32'(oWriteEn), 32'd0);
    check("rst/addr", 32'(oWriteAddress), 32'd0);
    check("rst/data", oDataIn, 32'd0);
    check("rst/pv", 32'(oPendingValid), 32'd0);
    check("rst/prd", 32'(oPendingRd), 32'd0);
    check("rst/count", oRetireCount, 32'd0);
    iRst = 1'b0;
    @(negedge iClk);
    check("rst/ready_after", 32'(oReadyM), 32'd1);

    run_op("addi", 5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0, 3'b000, 1, 32'h0);
    run_op("lb", 5'd7, 1'b1, 2'b01, 32'h0000_0102, 32'h0, 3'b000, 3, 32'h1280_7F00);
    run_op("lbu", 5'd8, 1'b1, 2'b01, 32'h0000_0102, 32'h0, 3'b100, 3, 32'h1280_7F00);
    run_op("lh", 5'd9, 1'b1, 2'b01, 32'h0000_0202, 32'h0, 3'b001, 1, 32'h8001_0000);
    run_op("lhu", 5'd10, 1'b1, 2'b01, 32'h0000_0203, 32'h0, 3'b101, 2, 32'h8001_0000);
    run_op("lw", 5'd11, 1'b1, 2'b01, 32'h0000_0010, 32'h0, 3'b010, 1, 32'hDEAD_BEEF);
    run_op("load_norw", 5'd12, 1'b0, 2'b01, 32'h0000_0011, 32'h0, 3'b000, 2, 32'h0000_8000);
    run_op("jal", 5'd1, 1'b1, 2'b10, 32'h0000_0FFF, 32'h0000_0104, 3'b000, 1, 32'h0);
    run_op("src11", 5'd2, 1'b1, 2'b11, 32'hCAFE_0001, 32'h0000_0200, 3'b000, 1, 32'h0);

    // Back-to-back non-loads, one per cycle
    for (int i = 0; i < 4; i++) begin
      iValidM = 1'b1; iRegWriteM = 1'b1; iRdM = 5'(i); iResultSrcM = 2'b00;
      iAluResultM = 32'h100 + 32'(i);
      @(negedge iClk);
      check("b2b/ready", 32'(oReadyM), 32'd1);
      check("b2b/we", 32'(oWriteEn), (i == 0) ? 32'd0 : 32'd1);
      check("b2b/addr", 32'(oWriteAddress), 32'(i));
      check("b2b/data", oDataIn, 32'h100 + 32'(i));
      exp_count++;
      last_addr = 5'(i);
      last_data = 32'h100 + 32'(i);
    end
    iValidM = 1'b0;
    @(negedge iClk);
    check("b2b/count", oRetireCount, exp_count);
    check("b2b/we_after", 32'(oWriteEn), 32'd0);

    // Stray response while idle must not disturb anything
    iMemRespValid = 1'b1; iMemRespData = 32'h5555_AAAA;
    @(negedge iClk);
    iMemRespValid = 1'b0;
    @(negedge iClk);
    check("spur/we", 32'(oWriteEn), 32'd0);
    check("spur/ready", 32'(oReadyM), 32'd1);
    check("spur/pv", 32'(oPendingValid), 32'd0);
    check("spur/addr", 32'(oWriteAddress), 32'(last_addr));
    check("spur/data", oDataIn, last_data);
    check("spur/count", oRetireCount, exp_count);

    // Randomized mix of loads and non-loads
    for (int n = 0; n < 40; n++) begin
      r_src = 2'($urandom);
      r_f3  = 3'($urandom);
      run_op($sformatf("rand%0d", n), 5'($urandom), 1'($urandom), r_src, $urandom,
             $urandom, r_f3, int'($urandom_range(1, 4)), $urandom);
    end

    // Reset while waiting for a load abandons it
    iValidM = 1'b1; iRegWriteM = 1'b1; iRdM = 5'd20; iResultSrcM = 2'b01;
    iAluResultM = 32'h0; iFunct3M = 3'b010;
    @(negedge iClk);
    iValidM = 1'b0;
    check("rstwait/pv", 32'(oPendingValid), 32'd1);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0; iMemRespValid = 1'b1; iMemRespData = 32'h1234_5678;
    @(negedge iClk);
    iMemRespValid = 1'b0;
    @(negedge iClk);
    exp_count = 0;
    check("rstwait/we", 32'(oWriteEn), 32'd0);
    check("rstwait/addr", 32'(oWriteAddress), 32'd0);
    check("rstwait/data", oDataIn, 32'd0);
    check("rstwait/pv_after", 32'(oPendingValid), 32'd0);
    check("rstwait/prd", 32'(oPendingRd), 32'd0);
    check("rstwait/count", oRetireCount, exp_count);
    check("rstwait/ready", 32'(oReadyM), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
